ifetch_ctrl: RTL and testbench
==============================

# ifetch_ctrl

Instruction-fetch controller that sequences the instruction memory for the IF stage of the MIPS pipeline. It owns the fetch PC, issues one read per cycle to imem, and tracks the returned word against its PC. It absorbs decode-stage stalls with a one-entry skid buffer and applies branch/jump redirects. It sits between the pipeline control (stall/redirect from ID/EX) and imem, and presents an (instruction, PC, valid) triple to the IF/ID register.

## Interface
- RESET_PC, 0: fetch address after reset; bits [1:0] must be 0.
- PC_STEP, 4: PC increment per sequential fetch.
- Widths `PC_WIDTH` and `IWIDTH` come from header.vh.
- im_clk  in  1  clock.
- im_rst  in  1  reset, asynchronous, active-low.
- fc_i_en  in  1  fetch enable; 0 halts issue.
- fc_i_stall  in  1  decode cannot accept this cycle.
- fc_i_redirect  in  1  branch/jump taken; one-cycle pulse.
- fc_i_target  in  PC_WIDTH  redirect address.
- fc_o_im_ce  out  1  imem read enable (to im_i_ce).
- fc_o_im_addr  out  PC_WIDTH  imem address (to im_i_address).
- fc_i_im_instr  in  IWIDTH  imem data (from im_o_instr).
- fc_i_im_ce  in  1  imem data valid (from im_o_ce).
- fc_o_instr  out  IWIDTH  instruction to IF/ID.
- fc_o_pc  out  PC_WIDTH  PC of fc_o_instr.
- fc_o_valid  out  1  fc_o_instr/fc_o_pc meaningful.
- fc_o_misalign  out  1  registered pulse: last redirect target had nonzero bits [1:0].

## Operation
- The FSM has three states:
  - BOOT: first cycle after reset release. Performs no issue, then moves to RUN if fc_i_en=1, else to HALT.
  - RUN: normal fetch.
  - HALT: no issue. Moves to RUN when fc_i_en=1. An in-flight response still lands in the output/skid path.
- Issue rule in RUN: fc_o_im_ce=1 when ~fc_i_stall | fc_i_redirect.
  - Address is fc_i_target with bits [1:0] forced to 0 on redirect, else pc.
  - req_pc captures the issued address.
  - pc advances to issued address + PC_STEP, modulo 2^PC_WIDTH (wraps silently).
- Response: imem returns data exactly 1 cycle after issue. This block pairs the data with req_pc.
- Output mux:
  - If the skid is full, drive the skid entry.
  - Otherwise, drive imem data and req_pc.
  - fc_o_valid = skid_full | fc_i_im_ce, forced 0 in a redirect cycle.
- Skid capture: when fc_i_stall=1, fc_i_im_ce=1 and the skid is empty, write {instr, req_pc} into the skid. This is required because imem zeroes its output once ce drops. No issue occurs while stalled, so the skid never overflows.
- Skid drain: in the first cycle with fc_i_stall=0, the skid entry is presented and cleared. Fetch at pc issues in the same cycle, so there is no loss and no duplicate.
- Redirect has priority over stall and en:
  - Clears the skid.
  - Drops the response arriving that cycle.
  - Issues at the target.
- Redirect in HALT or BOOT is only loaded into pc. No issue occurs.

## Timing
- Reset values:
  - fc_o_im_ce=0, fc_o_im_addr=RESET_PC, fc_o_instr=0, fc_o_pc=0, fc_o_valid=0, fc_o_misalign=0.
  - pc=RESET_PC, skid empty, state BOOT.
- Issue-to-valid latency is 1 cycle. After reset release, the first valid appears at cycle 2 (BOOT, issue, data).
- Throughput: 1 instruction/cycle when unstalled.
- fc_o_im_ce and fc_o_im_addr are combinational from state, pc, stall and redirect. All state is registered on im_clk.
- Reset asserted mid-operation clears all state asynchronously. Any in-flight response is discarded because imem also resets.
- fc_o_misalign is valid the cycle after the redirect, for 1 cycle.

## Configuration
- IFETCH_PERF_EN defined adds two outputs:
  - fc_o_fetch_cnt [31:0]: cycles with fc_o_valid & ~fc_i_stall.
  - fc_o_bubble_cnt [31:0]: RUN cycles with fc_o_valid=0.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- IFETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- header.vh gains:
  - FSM state encodings `IF_BOOT`, `IF_RUN`, `IF_HALT` (2 bits).
  - `PC_STEP_DEFAULT`.
- One sub-module: if_skid, a one-entry {instr, pc} buffer with load/drain/flush.

## Test plan
- Reset, en=1, imem preloaded with word(i)=i, RESET_PC=0:
  - Addresses 0,4,8,… issue from cycle 1.
  - Valid from cycle 2 with instr=0,1,2 and pc=0,4,8.
- Stall held 3 cycles while a response is in flight:
  - Skid holds pc=8, instr=2, and fc_o_im_ce=0 throughout.
  - On release, pc=8 is output, then 12 next, with no gap or duplicate.
- Redirect to 0x40 mid-stream:
  - Valid is 0 in the redirect cycle.
  - The next valid is pc=0x40, followed by 0x44.
- Redirect to 0x42 with stall=1:
  - The issue address is 0x40.
  - fc_o_misalign pulses.
  - The response is held in the skid until stall drops.
- pc=2^PC_WIDTH−4 sequential: the next fetch address is 0.
- Reset asserted with the skid full: all outputs go to reset values immediately, and the first post-reset fetch is RESET_PC.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared widths, FSM encodings and helpers for the IF-stage fetch controller.
package ifetch_ctrl_pkg;
  localparam int PC_WIDTH        = 32;
  localparam int IWIDTH          = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_RUN  = 2'd1,
    IF_HALT = 2'd2
  } if_state_e;

  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] a);
    return a & ~PC_WIDTH'(3);
  endfunction
endpackage

// File: rtl/ifetch_ctrl_skid.sv
// One-entry {instr, pc} holding buffer; 0-cycle read, load when empty, drain or flush clears.
module if_skid
  import ifetch_ctrl_pkg::*;
(
  input  logic                im_clk,
  input  logic                im_rst,
  input  logic                load,
  input  logic                drain,
  input  logic                flush,
  input  logic [IWIDTH-1:0]   in_instr,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                full,
  output logic [IWIDTH-1:0]   instr,
  output logic [PC_WIDTH-1:0] pc
);
  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      full  <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full  <= 1'b1;
      instr <= in_instr;
      pc    <= in_pc;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/ifetch_ctrl.sv
// IF-stage fetch controller: one imem read per cycle, 1-cycle issue-to-valid, stalls absorbed by a skid entry.
// IFETCH_PERF_EN adds saturating fetch/bubble counters.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(PC_STEP_DEFAULT)
) (
  input  logic                im_clk,
  input  logic                im_rst,
  input  logic                fc_i_en,
  input  logic                fc_i_stall,
  input  logic                fc_i_redirect,
  input  logic [PC_WIDTH-1:0] fc_i_target,
  output logic                fc_o_im_ce,
  output logic [PC_WIDTH-1:0] fc_o_im_addr,
  input  logic [IWIDTH-1:0]   fc_i_im_instr,
  input  logic                fc_i_im_ce,
  output logic [IWIDTH-1:0]   fc_o_instr,
  output logic [PC_WIDTH-1:0] fc_o_pc,
  output logic                fc_o_valid,
`ifdef IFETCH_PERF_EN
  output logic [31:0]         fc_o_fetch_cnt,
  output logic [31:0]         fc_o_bubble_cnt,
`endif
  output logic                fc_o_misalign
);
  if_state_e             state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, req_pc, addr;
  logic                  issue;
  logic                  skid_full, skid_load, skid_drain;
  logic [IWIDTH-1:0]     skid_instr;
  logic [PC_WIDTH-1:0]   skid_pc;

  // Redirect wins over stall and enable; dropping en stops issue immediately.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IF_BOOT: state_nxt = fc_i_en ? IF_RUN : IF_HALT;
      IF_RUN: begin
        issue     = (fc_i_en & ~fc_i_stall) | fc_i_redirect;
        state_nxt = fc_i_en ? IF_RUN : IF_HALT;
      end
      IF_HALT: if (fc_i_en) state_nxt = IF_RUN;
      default: state_nxt = IF_BOOT;
    endcase
  end

  assign addr         = fc_i_redirect ? align_word(fc_i_target) : pc;
  assign fc_o_im_ce   = issue;
  assign fc_o_im_addr = addr;

  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      state         <= IF_BOOT;
      pc            <= RESET_PC;
      req_pc        <= '0;
      fc_o_misalign <= 1'b0;
    end else begin
      state         <= state_nxt;
      fc_o_misalign <= fc_i_redirect & (|fc_i_target[1:0]);
      if (issue) begin
        pc     <= addr + PC_STEP;
        req_pc <= addr;
      end else if (fc_i_redirect) begin
        pc <= align_word(fc_i_target);
      end
    end
  end

  // imem clears its data once ce drops, so a stalled response must be parked here.
  assign skid_load  = fc_i_stall & fc_i_im_ce & ~skid_full & ~fc_i_redirect;
  assign skid_drain = ~fc_i_stall & skid_full;

  if_skid u_skid (
    .im_clk   (im_clk),
    .im_rst   (im_rst),
    .load     (skid_load),
    .drain    (skid_drain),
    .flush    (fc_i_redirect),
    .in_instr (fc_i_im_instr),
    .in_pc    (req_pc),
    .full     (skid_full),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  assign fc_o_instr = skid_full ? skid_instr : fc_i_im_instr;
  assign fc_o_pc    = skid_full ? skid_pc    : req_pc;
  assign fc_o_valid = (skid_full | fc_i_im_ce) & ~fc_i_redirect;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      fc_o_fetch_cnt  <= '0;
      fc_o_bubble_cnt <= '0;
    end else begin
      if (fc_o_valid && !fc_i_stall && fc_o_fetch_cnt != 32'hFFFF_FFFF)
        fc_o_fetch_cnt <= fc_o_fetch_cnt + 32'd1;
      if (state == IF_RUN && !fc_o_valid && fc_o_bubble_cnt != 32'hFFFF_FFFF)
        fc_o_bubble_cnt <= fc_o_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Table-driven bench for ifetch_ctrl with a word(i)=i imem model and an expectation queue.
module tb_ifetch_ctrl;
  import ifetch_ctrl_pkg::*;

  logic                im_clk = 1'b0;
  logic                im_rst = 1'b0;
  logic                en, stall, redir;
  logic [PC_WIDTH-1:0] tgt;
  logic                im_ce;
  logic [PC_WIDTH-1:0] im_addr;
  logic [IWIDTH-1:0]   im_instr;
  logic                im_vld;
  logic [IWIDTH-1:0]   o_instr;
  logic [PC_WIDTH-1:0] o_pc;
  logic                o_valid, o_mis;

  always #5 im_clk = ~im_clk;

  ifetch_ctrl dut (
    .im_clk        (im_clk),
    .im_rst        (im_rst),
    .fc_i_en       (en),
    .fc_i_stall    (stall),
    .fc_i_redirect (redir),
    .fc_i_target   (tgt),
    .fc_o_im_ce    (im_ce),
    .fc_o_im_addr  (im_addr),
    .fc_i_im_instr (im_instr),
    .fc_i_im_ce    (im_vld),
    .fc_o_instr    (o_instr),
    .fc_o_pc       (o_pc),
    .fc_o_valid    (o_valid),
    .fc_o_misalign (o_mis)
  );

  // imem: one-cycle read, word(i)=i, output zeroed when not enabled
  always @(posedge im_clk or negedge im_rst) begin
    if (!im_rst) begin
      im_instr <= '0;
      im_vld   <= 1'b0;
    end else if (im_ce) begin
      im_instr <= IWIDTH'(im_addr >> 2);
      im_vld   <= 1'b1;
    end else begin
      im_instr <= '0;
      im_vld   <= 1'b0;
    end
  end

  typedef struct packed {
    logic        en, stall, redir;
    logic [31:0] tgt;
    logic        e_ce;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_mis;
  } vec_t;

  vec_t tbl[22];
  vec_t sb_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t mk(input logic e, input logic s, input logic r, input logic [31:0] t,
                              input logic ce, input logic [31:0] ad, input logic v,
                              input logic [31:0] p, input logic [31:0] ins, input logic m);
    vec_t x;
    x.en = e; x.stall = s; x.redir = r; x.tgt = t;
    x.e_ce = ce; x.e_addr = ad; x.e_vld = v; x.e_pc = p; x.e_instr = ins; x.e_mis = m;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    en = v.en; stall = v.stall; redir = v.redir; tgt = v.tgt;
    sb_q.push_back(v);
  endtask

  task automatic sample(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      n_tot++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, ".ce"},    32'(im_ce),   32'(e.e_ce));
    chk({tag, ".addr"},  im_addr,      e.e_addr);
    chk({tag, ".valid"}, 32'(o_valid), 32'(e.e_vld));
    chk({tag, ".mis"},   32'(o_mis),   32'(e.e_mis));
    if (e.e_vld) begin
      chk({tag, ".pc"},    o_pc,    e.e_pc);
      chk({tag, ".instr"}, o_instr, e.e_instr);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge im_clk);
    drive(v);
    #2 sample(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ce"},    32'(im_ce),   0);
    chk({tag, ".addr"},  im_addr,      0);
    chk({tag, ".instr"}, o_instr,      0);
    chk({tag, ".pc"},    o_pc,         0);
    chk({tag, ".valid"}, 32'(o_valid), 0);
    chk({tag, ".mis"},   32'(o_mis),   0);
  endtask

  initial begin
    //           en st rd tgt           ce addr          vld pc            instr         mis
    tbl[0]  = mk(1, 0, 0, 0,            0, 0,            0, 0,            0,            0);
    tbl[1]  = mk(1, 0, 0, 0,            1, 0,            0, 0,            0,            0);
    tbl[2]  = mk(1, 0, 0, 0,            1, 4,            1, 0,            0,            0);
    tbl[3]  = mk(1, 0, 0, 0,            1, 8,            1, 4,            1,            0);
    tbl[4]  = mk(1, 1, 0, 0,            0, 12,           1, 8,            2,            0);
    tbl[5]  = mk(1, 1, 0, 0,            0, 12,           1, 8,            2,            0);
    tbl[6]  = mk(1, 1, 0, 0,            0, 12,           1, 8,            2,            0);
    tbl[7]  = mk(1, 0, 0, 0,            1, 12,           1, 8,            2,            0);
    tbl[8]  = mk(1, 0, 0, 0,            1, 16,           1, 12,           3,            0);
    tbl[9]  = mk(1, 0, 1, 32'h40,       1, 32'h40,       0, 0,            0,            0);
    tbl[10] = mk(1, 0, 0, 0,            1, 32'h44,       1, 32'h40,       32'h10,       0);
    tbl[11] = mk(1, 0, 0, 0,            1, 32'h48,       1, 32'h44,       32'h11,       0);
    tbl[12] = mk(1, 1, 1, 32'h42,       1, 32'h40,       0, 0,            0,            0);
    tbl[13] = mk(1, 1, 0, 0,            0, 32'h44,       1, 32'h40,       32'h10,       1);
    tbl[14] = mk(1, 1, 0, 0,            0, 32'h44,       1, 32'h40,       32'h10,       0);
    tbl[15] = mk(1, 0, 0, 0,            1, 32'h44,       1, 32'h40,       32'h10,       0);
    tbl[16] = mk(1, 0, 0, 0,            1, 32'h48,       1, 32'h44,       32'h11,       0);
    tbl[17] = mk(1, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 0, 0,            0,            0);
    tbl[18] = mk(1, 0, 0, 0,            1, 0,            1, 32'hFFFFFFFC, 32'h3FFFFFFF, 0);
    tbl[19] = mk(1, 0, 0, 0,            1, 4,            1, 0,            0,            0);
    tbl[20] = mk(1, 1, 0, 0,            0, 8,            1, 4,            1,            0);
    tbl[21] = mk(1, 1, 0, 0,            0, 8,            1, 4,            1,            0);

    en = 1'b1; stall = 1'b0; redir = 1'b0; tgt = '0;
    repeat (2) @(negedge im_clk);
    #2 chk_reset_outputs("reset");

    @(negedge im_clk);
    im_rst = 1'b1;
    drive(tbl[0]);
    #2 sample("v0");
    for (int i = 1; i < 22; i++) step(tbl[i], $sformatf("v%0d", i));

    // skid is full here; asynchronous reset must clear everything mid-cycle
    #1 im_rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    @(negedge im_clk);
    @(negedge im_clk);
    im_rst = 1'b1;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 sample("post0");
    step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0), "post1");
    step(mk(1, 0, 0, 0, 1, 4, 1, 0, 0, 0), "post2");

    // boot into HALT, redirect there only loads pc
    @(negedge im_clk);
    en = 1'b0;
    im_rst = 1'b0;
    @(negedge im_clk);
    im_rst = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 sample("halt0");
    step(mk(0, 0, 1, 32'h80, 0, 32'h80, 0, 0, 0, 0), "halt1");
    step(mk(1, 0, 0, 0,      0, 32'h80, 0, 0, 0, 0), "halt2");
    step(mk(1, 0, 0, 0,      1, 32'h80, 0, 0, 0, 0), "halt3");
    step(mk(1, 0, 0, 0,      1, 32'h84, 1, 32'h80, 32'h20, 0), "halt4");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
